// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int ITERS_DEF = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Single radix-2 step: shift-add multiply or restoring trial-subtract divide.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   opnd,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0] sum;
    logic [XLEN:0] trial;

    always_comb begin
        sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
        trial = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
        if (is_div) begin
            // No borrow means the shifted remainder covers the divisor.
            if (!trial[XLEN]) begin
                acc_next = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end else begin
                acc_next = {acc[2*XLEN-2:0], 1'b0};
            end
        end else if (acc[0]) begin
            acc_next = {sum, acc[XLEN-1:1]};
        end else begin
            acc_next = {1'b0, acc[2*XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit with valid/ready handshakes.
// Magnitudes iterate one bit per cycle; the sign is applied on completion.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int ITERS = ITERS_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(ITERS + 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    op_e               op_q, op_d;
    logic [2*XLEN-1:0] acc_q, acc_d, acc_step;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              neg_q, neg_d;

    op_e               op_in;
    logic              accept, last;
    logic              sgn_a, sgn_b, b_zero, ovf, special;
    logic [XLEN-1:0]   mag_a, mag_b, spec_res, fin;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;

    assign op_in     = op_e'(op);
    assign in_ready  = (state_q == IDLE) && !flush;
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign accept    = in_valid && in_ready;
    assign last      = (count_q == CW'(ITERS - 1));

    // Operand decode: effective signs, magnitudes and bypass cases.
    always_comb begin
        sgn_a = operand_a[XLEN-1] && (op_in == OP_MULH || op_in == OP_MULHSU ||
                                      op_in == OP_DIV  || op_in == OP_REM);
        sgn_b = operand_b[XLEN-1] && (op_in == OP_MULH || op_in == OP_DIV ||
                                      op_in == OP_REM);
        mag_a  = sgn_a ? -operand_a : operand_a;
        mag_b  = sgn_b ? -operand_b : operand_b;
        b_zero = (operand_b == '0);
        ovf    = (op_in == OP_DIV || op_in == OP_REM) &&
                 (operand_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                 (operand_b == '1);
        special = op[2] && (b_zero || ovf);
        if (b_zero) begin
            spec_res = op[1] ? operand_a : '1;
        end else begin
            spec_res = op[1] ? '0 : operand_a;
        end
    end

    muldiv_iter #(
        .XLEN     (XLEN)
    ) u_iter (
        .is_div   (op_q[2]),
        .acc      (acc_q),
        .opnd     (opnd_q),
        .acc_next (acc_step)
    );

    always_comb begin
        prod = neg_q ? -acc_step : acc_step;
        quo  = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
        rem  = neg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
        unique case (op_q)
            OP_MUL:                       fin = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fin = quo;
            default:                      fin = rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = special ? DONE : BUSY;
            BUSY: if (last) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_comb begin
        count_d  = count_q;
        op_d     = op_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        result_d = result_q;
        if (flush) begin
            result_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        count_d = '0;
                        op_d    = op_in;
                        neg_d   = (op_in == OP_REM) ? sgn_a : (sgn_a ^ sgn_b);
                        acc_d   = {{XLEN{1'b0}}, op[2] ? mag_a : mag_b};
                        opnd_d  = op[2] ? mag_b : mag_a;
                        if (special) result_d = spec_res;
                    end
                end
                BUSY: begin
                    acc_d   = acc_step;
                    count_d = count_q + CW'(1);
                    if (last) result_d = fin;
                end
                DONE: if (out_ready) result_d = '0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            op_q     <= OP_MUL;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            count_q  <= count_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 Parameter ITERS, default 32, iteration cycles per non-special operation.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 operand_a  input  32  rs1 value (multiplicand/dividend).
REQ-009 operand_b  input  32  rs2 value (multiplier/divisor).
REQ-010 flush  input  1  abort any in-flight or completed-but-unconsumed operation.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 result  output  32  operation result, RISC-V M-extension semantics.

Function
REQ-014 FSM states: IDLE, BUSY, DONE; in_ready = (state==IDLE) && !flush; out_valid = (state==DONE).
REQ-015 Accept when in_valid && in_ready at a rising edge: capture op, operands, sign flags; count <= 0; go to BUSY, except special cases (REQ-019/020), which go directly to DONE.
REQ-016 BUSY: one radix-2 step per cycle (shift-add multiply, restoring divide on magnitudes, 64-bit product/remainder-quotient register); count increments; after ITERS steps go to DONE.
REQ-017 Latency: acceptance at edge k; out_valid high from edge k+ITERS+1 (k+33 default); special cases from edge k+1.
REQ-018 Signed ops use magnitudes internally; final sign applied when entering DONE: MUL low 32 bits; MULH signed x signed high; MULHSU signed rs1 x unsigned rs2 high; MULHU unsigned high; quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
REQ-019 Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> operand_a; no iteration.
REQ-020 Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV -> 0x80000000, REM -> 0; no iteration.
REQ-021 DONE: result and out_valid held stable until out_valid && out_ready at an edge, then IDLE; no new request is accepted in the same cycle.
REQ-022 result = 0 whenever out_valid is low.
REQ-023 flush high at an edge: state <= IDLE from any state, result discarded, no out_valid; in_ready low while flush is high; flush takes priority over completion and acceptance.
REQ-024 Inputs are ignored outside IDLE; operands need not be held after acceptance.

Reset
REQ-025 rst high at an edge: state IDLE, count 0, internal registers 0; out_valid 0, result 0, in_ready 1 after release.
REQ-026 rst mid-operation or in DONE: operation dropped, no out_valid; rst priority over flush and handshakes.

Structure
REQ-027 Package muldiv_pkg holds: op encoding enum (funct3 values of REQ-007), FSM state enum, XLEN and ITERS default constants.
REQ-028 One sub-module, muldiv_iter: combinational single-step unit (add/shift for multiply, trial-subtract/shift for divide); muldiv_seq owns the FSM, counter, operand and sign registers.
REQ-029 All outputs registered or derived only from state/registers; no combinational path from operand inputs to result.

Verification
REQ-030 MUL 7 x 0xFFFFFFFD (-3), out_ready=1 -> result 0xFFFFFFEB, out_valid first at acceptance+33, one cycle wide.
REQ-031 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-032 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at acceptance+1; REM same operands -> 0; DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF.
REQ-033 DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, both at acceptance+1.
REQ-034 DIVU 100/7 with out_ready low 5 cycles after out_valid -> result 14 held stable, in_ready low throughout, IDLE one edge after out_ready rises.
REQ-035 flush at acceptance+10 of a MUL -> IDLE next edge, out_valid never asserted; following REMU 100/7 -> 2; rst asserted mid-DIV yields identical behaviour.
